uart_tx_ctrl: RTL and testbench

Frame sequencer for the UART transmitter datapath. It accepts a parallel byte over a valid/ready handshake and generates the bit-period timing. It serialises start, data (LSB first), optional parity and stop bits onto tx_serial. It also exports one-cycle write (load) and shift strobes, so the flop-based shift register stage downstream stays in lockstep with the frame.

---
 rtl/uart_tx_ctrl_pkg.sv | 21 ++
 rtl/uart_tx_ctrl_if.sv | 25 ++
 rtl/uart_baud_counter.sv | 31 +++
 rtl/uart_tx_ctrl.sv | 138 +++++++++++++
 tb/tb_uart_tx_ctrl.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_ctrl_pkg.sv
// Shared types and helpers for the UART transmit frame sequencer.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam int DEFAULT_CLKS_PER_BIT = 868;
  localparam int MAX_DATA_BITS        = 9;

  // Zero padding up to MAX_DATA_BITS leaves the XOR unchanged.
  function automatic logic parity_calc(input logic [MAX_DATA_BITS-1:0] data,
                                       input logic                     odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Byte handshake plus serial line and shift-register strobes of the UART transmitter.
interface uart_tx_ctrl_if #(
  parameter int DATA_BITS = 8
);

  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic                 tx_serial;
  logic                 tx_busy;
  logic                 tx_done;
  logic                 write;
  logic                 shift;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, tx_serial, tx_busy, tx_done, write, shift
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, tx_serial, tx_busy, tx_done, write, shift
  );

endinterface

// File: rtl/uart_baud_counter.sv
// Bit-period timer: bit_end pulses on every CLKS_PER_BIT-th enabled cycle.
module uart_baud_counter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic bit_end
);

  localparam int              CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign bit_end = en && (cnt == CNT_LAST);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: start, LSB-first data, optional parity, stop bits,
// with load/shift strobes that keep an external shift register in lockstep.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic           clk,
  input  logic           reset,
  uart_tx_ctrl_if.slave  bus
);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks
    $error("uart_tx_ctrl: CLKS_PER_BIT must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > MAX_DATA_BITS) begin : g_bad_data
    $error("uart_tx_ctrl: DATA_BITS must be 5..9");
  end
  if (PARITY_EN != 0 && PARITY_EN != 1) begin : g_bad_par_en
    $error("uart_tx_ctrl: PARITY_EN must be 0 or 1");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_par_odd
    $error("uart_tx_ctrl: PARITY_ODD must be 0 or 1");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_ctrl: STOP_BITS must be 1 or 2");
  end

  localparam int               IDX_W    = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  tx_state_t            state;
  tx_state_t            state_next;
  logic [DATA_BITS-1:0] data_q;
  logic                 parity_q;
  logic [IDX_W-1:0]     bit_idx;
  logic [IDX_W-1:0]     bit_idx_next;
  logic                 stop_cnt;
  logic                 stop_cnt_next;
  logic                 serial_p1;
  logic                 serial_next;
  logic                 done_p1;
  logic                 done_next;
  logic                 accept;
  logic                 bit_end;
  logic                 data_last;
  logic                 stop_last;

  // No load strobe while reset is held, even though the FSM reads as IDLE.
  assign accept    = bus.tx_valid && (state == IDLE) && reset;
  assign data_last = (bit_idx == IDX_LAST);
  assign stop_last = (stop_cnt == 1'(STOP_BITS - 1));

  uart_baud_counter #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .reset   (reset),
    .clear   (accept),
    .en      (state != IDLE),
    .bit_end (bit_end)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = START;
      START:   if (bit_end) state_next = DATA;
      DATA:    if (bit_end && data_last) state_next = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY:  if (bit_end) state_next = STOP;
      STOP:    if (bit_end && stop_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bit_idx_next  = bit_idx;
    stop_cnt_next = stop_cnt;
    if (accept) begin
      bit_idx_next  = '0;
      stop_cnt_next = 1'b0;
    end else begin
      if (state == DATA && bit_end && !data_last) bit_idx_next = bit_idx + 1'b1;
      if (state == STOP && bit_end && !stop_last) stop_cnt_next = 1'b1;
    end
  end

  // Line level is registered from the upcoming state so it changes on the bit boundary edge.
  always_comb begin
    bus.tx_ready = (state == IDLE);
    bus.tx_busy  = (state != IDLE);
    bus.write    = accept;
    bus.shift    = bit_end && (state == START || state == DATA);
    done_next    = (state == STOP) && bit_end && stop_last;
    case (state_next)
      START:   serial_next = 1'b0;
      DATA:    serial_next = data_q[bit_idx_next];
      PARITY:  serial_next = parity_q;
      default: serial_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q    <= '0;
      parity_q  <= 1'b0;
      bit_idx   <= '0;
      stop_cnt  <= 1'b0;
      serial_p1 <= 1'b1;
      done_p1   <= 1'b0;
    end else begin
      bit_idx   <= bit_idx_next;
      stop_cnt  <= stop_cnt_next;
      serial_p1 <= serial_next;
      done_p1   <= done_next;
      if (accept) begin
        data_q   <= bus.tx_data;
        parity_q <= parity_calc(MAX_DATA_BITS'(bus.tx_data), PARITY_ODD != 0);
      end
    end
  end

  assign bus.tx_serial = serial_p1;
  assign bus.tx_done   = done_p1;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: 8N1, even/odd parity, two stop bits, reset and busy abuse.
module tb_uart_tx_ctrl;

  localparam int CPB = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   sel   = 0;

  always #5 clk = ~clk;

  uart_tx_ctrl_if #(.DATA_BITS(8)) if0 ();
  uart_tx_ctrl_if #(.DATA_BITS(8)) if1 ();
  uart_tx_ctrl_if #(.DATA_BITS(8)) if2 ();
  uart_tx_ctrl_if #(.DATA_BITS(8)) if3 ();

  uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
    u_8n1 (.clk(clk), .reset(reset), .bus(if0));
  uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1))
    u_even (.clk(clk), .reset(reset), .bus(if1));
  uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1))
    u_odd (.clk(clk), .reset(reset), .bus(if2));
  uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2))
    u_2stop (.clk(clk), .reset(reset), .bus(if3));

  logic m_ser, m_done, m_wr, m_sh, m_rdy, m_busy;

  always_comb begin
    {m_ser, m_done, m_wr, m_sh, m_rdy, m_busy} =
      {if0.tx_serial, if0.tx_done, if0.write, if0.shift, if0.tx_ready, if0.tx_busy};
    case (sel)
      1: {m_ser, m_done, m_wr, m_sh, m_rdy, m_busy} =
           {if1.tx_serial, if1.tx_done, if1.write, if1.shift, if1.tx_ready, if1.tx_busy};
      2: {m_ser, m_done, m_wr, m_sh, m_rdy, m_busy} =
           {if2.tx_serial, if2.tx_done, if2.write, if2.shift, if2.tx_ready, if2.tx_busy};
      3: {m_ser, m_done, m_wr, m_sh, m_rdy, m_busy} =
           {if3.tx_serial, if3.tx_done, if3.write, if3.shift, if3.tx_ready, if3.tx_busy};
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d);
    case (sel)
      1:       begin if1.tx_valid = v; if1.tx_data = d; end
      2:       begin if2.tx_valid = v; if2.tx_data = d; end
      3:       begin if3.tx_valid = v; if3.tx_data = d; end
      default: begin if0.tx_valid = v; if0.tx_data = d; end
    endcase
  endtask

  // Expected line samples for cycles 1..n; bits[0] is the start bit, idle high after the frame.
  function automatic logic [127:0] expand(input logic [15:0] bits, input int nbits, input int n);
    logic [127:0] w;
    w = '0;
    for (int c = 1; c <= n; c++)
      w[7'(c)] = (c <= nbits * CPB) ? bits[4'((c - 1) / CPB)] : 1'b1;
    return w;
  endfunction

  task automatic capture(input int n, input bit jam,
                         output logic [127:0] ser, output logic [127:0] don,
                         output int nsh, output int nwr, output int nrdy);
    logic [7:0] junk;
    junk = 8'hFF;
    ser = '0; don = '0; nsh = 0; nwr = 0; nrdy = 0;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      ser[7'(c)] = m_ser;
      don[7'(c)] = m_done;
      nsh += int'(m_sh);
      nwr += int'(m_wr);
      if (c < n) nrdy += int'(m_rdy);
      if (jam) begin
        drive(c < n - 1, junk);
        junk = junk ^ 8'h5A;
      end
    end
  endtask

  task automatic start_tx(input string tag, input logic [7:0] d, input bit hold);
    @(negedge clk);
    drive(1'b1, d);
    #1;
    chk({tag, "_write0"}, 128'(m_wr), 128'd1);
    chk({tag, "_ready0"}, 128'(m_rdy), 128'd1);
    @(posedge clk);
    #1;
    if (!hold) drive(1'b0, d);
  endtask

  task automatic frame(input string tag, input logic [7:0] d, input logic [15:0] bits,
                       input int nbits, input bit jam);
    logic [127:0] ser, don;
    int nsh, nwr, nrdy, n;
    n = nbits * CPB + 1;
    start_tx(tag, d, 1'b0);
    capture(n, jam, ser, don, nsh, nwr, nrdy);
    chk({tag, "_line"},  ser, expand(bits, nbits, n));
    chk({tag, "_done"},  don, 128'd1 << n);
    chk({tag, "_shift"}, 128'(nsh), 128'd9);
    chk({tag, "_wr"},    128'(nwr), 128'd0);
    chk({tag, "_rdy"},   128'(nrdy), 128'd0);
    chk({tag, "_idle"},  128'({m_rdy, m_busy}), 128'b10);
  endtask

  initial begin
    logic [127:0] ser, don;
    int nsh, nwr, nrdy;
    for (int s = 0; s < 4; s++) begin
      sel = s;
      drive(1'b0, 8'h00);
    end
    #2 reset = 1'b0;

    // Reset held with random traffic
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      for (int s = 0; s < 4; s++) begin
        sel = s;
        drive((i == 0) ? 1'b1 : 1'($urandom_range(0, 1)), 8'($urandom));
      end
      for (int s = 0; s < 4; s++) begin
        sel = s;
        #1;
        chk("rst_outs", 128'({m_ser, m_rdy, m_busy, m_done, m_wr, m_sh}), 128'b110000);
      end
    end
    @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      sel = s;
      drive(1'b0, 8'h00);
    end
    reset = 1'b1;
    sel   = 0;
    repeat (2) @(negedge clk);

    // 8N1 frames and parity variants
    sel = 0;
    frame("t2_a5", 8'hA5, {6'b0, 1'b1, 8'hA5, 1'b0}, 10, 1'b0);
    sel = 1;
    frame("t3_even", 8'h07, {5'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11, 1'b0);
    sel = 2;
    frame("t3_odd", 8'h07, {5'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11, 1'b0);

    // Two stop bits, back-to-back with tx_valid held
    sel = 3;
    start_tx("t4_a", 8'h55, 1'b1);
    drive(1'b1, 8'hAA);
    capture(45, 1'b0, ser, don, nsh, nwr, nrdy);
    chk("t4_a_line",  ser, expand({4'b0, 2'b11, 8'h55, 1'b0}, 11, 45));
    chk("t4_a_done",  don, 128'd1 << 45);
    chk("t4_a_shift", 128'(nsh), 128'd9);
    chk("t4_a_wr",    128'(nwr), 128'd1);
    chk("t4_a_rdy",   128'(nrdy), 128'd0);
    chk("t4_b_acc",   128'({m_wr, m_rdy, m_done}), 128'b111);
    @(posedge clk);
    #1;
    drive(1'b0, 8'hAA);
    capture(45, 1'b0, ser, don, nsh, nwr, nrdy);
    chk("t4_b_line",  ser, expand({4'b0, 2'b11, 8'hAA, 1'b0}, 11, 45));
    chk("t4_b_done",  don, 128'd1 << 45);
    chk("t4_b_shift", 128'(nsh), 128'd9);
    chk("t4_b_wr",    128'(nwr), 128'd0);

    // Reset during data bit 3 of 0xF0
    sel = 0;
    start_tx("t5", 8'hF0, 1'b0);
    capture(18, 1'b0, ser, don, nsh, nwr, nrdy);
    chk("t5_bit3", 128'({m_ser, m_busy}), 128'b01);
    reset = 1'b0;
    #1;
    chk("t5_rst", 128'({m_ser, m_rdy, m_busy, m_done}), 128'b1100);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    capture(45, 1'b0, ser, don, nsh, nwr, nrdy);
    chk("t5_nodone", don, 128'd0);
    chk("t5_quiet",  ser, expand(16'd0, 0, 45));
    frame("t5_3c", 8'h3C, {6'b0, 1'b1, 8'h3C, 1'b0}, 10, 1'b0);

    // Traffic on the handshake while a frame is in flight
    frame("t6_81", 8'h81, {6'b0, 1'b1, 8'h81, 1'b0}, 10, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
